fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-side arbiter that lets NREQ independent producers share the single write port of the 8-entry, 8-bit synchronous FIFO. It sits directly in front of the FIFO's `buf_in`/`wr_en` inputs and observes its `buf_full` flag. It grants one producer at a time for a bounded burst and acknowledges each accepted word, so producers never push into a full buffer.

## Interface
- `NREQ`, 4, number of producers (2..8)
- `DATA_W`, 8, data width; must match FIFO `buf_in`
- `BURST_MAX`, 4, max words accepted per grant before forced rotation (1..15)
- `clock`  in  1  rising-edge clock shared with the FIFO
- `reset_n`  in  1  asynchronous active-low reset
- `req`  in  NREQ  per-producer request; level, held while the producer has data
- `req_data`  in  NREQ*DATA_W  producer i data at bits [i*DATA_W +: DATA_W]
- `ack`  out  NREQ  one-hot; `ack[i]`=1 means word from producer i is written this cycle
- `grant`  out  NREQ  registered one-hot current owner; all-zero when idle
- `buf_full`  in  1  FIFO full flag
- `buf_in`  out  DATA_W  FIFO write data
- `wr_en`  out  1  FIFO write enable

## Operation
- FSM states: ARB, OWN.
- ARB: if any `req` bit is set, select the first set bit searching upward from `rr_ptr`, wrapping modulo NREQ. Load the one-hot `grant`, clear `burst_cnt`, go to OWN. If no request, stay in ARB with `grant`=0.
- OWN, owner g:
  - `wr_en` = `req[g]` & ~`buf_full` (combinational).
  - `buf_in` = `req_data` slice g whenever in OWN; 0 in ARB.
  - `ack` = `grant` & {NREQ{`wr_en`}}.
  - Each `wr_en` cycle increments `burst_cnt`.
  - Release, back to ARB, when `req[g]`=0, or when a write occurs with `burst_cnt`=BURST_MAX-1. On release, `rr_ptr` = (g+1) mod NREQ and `grant` clears the next cycle.
  - `buf_full`=1 stalls: no write, `burst_cnt` holds, grant is held indefinitely.
- Producers may change `req_data` only after a cycle in which their `ack` is high. A producer dropping `req` mid-grant is legal; that cycle writes nothing.
- Non-owners' requests never cause writes, regardless of `buf_full`.

## Timing
- Reset (async assert, sync release): state=ARB, `grant`=0, `rr_ptr`=0, `burst_cnt`=0, `ack`=0, `wr_en`=0, `buf_in`=0.
- Arbitration latency: 1 cycle. `req` seen in ARB at edge N → `grant` valid after N → first write at edge N+1 if not full.
- Handover costs one ARB cycle. A full burst therefore occupies BURST_MAX+1 cycles, giving peak throughput BURST_MAX/(BURST_MAX+1).
- `wr_en`/`ack` are combinational from registered `grant` plus the `req`/`buf_full` inputs. No combinational path from `req_data` to control.
- Write and FIFO read in the same cycle while full: the FIFO's `buf_full` governs. The arbiter never writes while `buf_full`=1.
- `reset_n` low mid-burst: `grant`, `ack` and `wr_en` drop immediately (asynchronously). No partial word is acknowledged.
- `rr_ptr` wraps from NREQ-1 to 0.

## Test plan
- Reset then `req`=4'b0001, producer 0 streams 1,2,3,4,5. Required:
  - `grant`=0001 one cycle after `req`.
  - `ack` on 4 consecutive cycles, FIFO receives 1,2,3,4.
  - One ARB gap, then word 5 written.
- All four `req` high continuously, FIFO drained every cycle. Required:
  - Grants in order 0001→0010→0100→1000→0001, each with exactly 4 writes.
  - FIFO order is p0×4, p1×4, p2×4, p3×4.
- Fill the FIFO to 8 entries with producer 2 owning the grant. Required:
  - `wr_en`=0 and `ack`=0 while `buf_full`=1; grant stays 0100.
  - After one FIFO pop, exactly one write with `ack[2]`=1 and `burst_cnt` resuming.
- Producer 1 drops `req` after 2 words while producer 3 is requesting. Required:
  - Release after word 2.
  - Next `grant`=1000, since `rr_ptr`=2 and producer 2 is idle.
- Assert `reset_n`=0 mid-burst from producer 3. Required:
  - `wr_en`, `ack` and `grant` go to 0 before the next edge.
  - After release, the first grant goes to the lowest requesting index ≥0.
- Only producer 0 requests, BURST_MAX=1. Required: alternating write/ARB cycles and `grant` re-asserting 0001 every other cycle.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one synchronous FIFO write port among NREQ producers.
// Each grant is held for a bounded burst; every accepted word is acknowledged to its producer.
//
// state | meaning
// ARB   | no owner; grant=0, pick next requester searching upward from rr_ptr
// OWN   | one producer owns the write port until it drops req or its burst completes
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        ack,
    output logic [NREQ-1:0]        grant,
    input  logic                   buf_full,
    output logic [DATA_W-1:0]      buf_in,
    output logic                   wr_en
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [NREQ-1:0]  grant_nxt;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] owner_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_ptr_nxt;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_cnt_nxt;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W:0]   cand;
    logic             owner_req;
    logic             release_now;

    // Scan from the farthest offset down so the nearest requester at or above rr_ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NREQ)) begin
                cand = cand - (IDX_W + 1)'(NREQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Write control depends only on the registered grant and the req/buf_full inputs.
    always_comb begin
        owner_req = |(req & grant);
        wr_en     = (state == OWN) && owner_req && !buf_full;
        ack       = grant & {NREQ{wr_en}};
        buf_in    = '0;
        if (state == OWN) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i]) begin
                    buf_in = req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        release_now   = 1'b0;
        case (state)
            ARB: begin
                grant_nxt = '0;
                if (pick_valid) begin
                    state_nxt     = OWN;
                    grant_nxt     = NREQ'(1) << pick_idx;
                    owner_nxt     = pick_idx;
                    burst_cnt_nxt = '0;
                end
            end
            OWN: begin
                release_now = !owner_req || (wr_en && (burst_cnt == CNT_LAST));
                if (wr_en) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end
                if (release_now) begin
                    state_nxt     = ARB;
                    grant_nxt     = '0;
                    burst_cnt_nxt = '0;
                    rr_ptr_nxt    = (owner == LAST_IDX) ? '0 : owner + 1'b1;
                end
            end
            default: begin
                state_nxt = ARB;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ARB;
            grant     <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer queues and an 8-deep FIFO around the DUT, checked
// cycle by cycle against a grant/burst/round-robin reference model.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int BMAX = 4;
    localparam int IW   = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        buf_full = 1'b0;
    logic [7:0]  buf_in;
    logic        wr_en;

    logic [3:0]  req1 = '0;
    logic [31:0] req_data1 = '0;
    logic [3:0]  ack1;
    logic [3:0]  grant1;
    logic        buf_full1 = 1'b0;
    logic [7:0]  buf_in1;
    logic        wr_en1;

    fifo_wr_arbiter #(.NREQ(4), .DATA_W(8), .BURST_MAX(4)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data), .ack(ack),
        .grant(grant), .buf_full(buf_full), .buf_in(buf_in), .wr_en(wr_en)
    );

    fifo_wr_arbiter #(.NREQ(4), .DATA_W(8), .BURST_MAX(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .req(req1), .req_data(req_data1), .ack(ack1),
        .grant(grant1), .buf_full(buf_full1), .buf_in(buf_in1), .wr_en(wr_en1)
    );

    always #5 clock = ~clock;

    // producer queues and FIFO environment
    logic [7:0]      pdata [NREQ][64];
    int              phead [NREQ];
    int              plen  [NREQ];
    logic [NREQ-1:0] req_en = '1;
    logic [7:0]      fq[$];
    logic            pop_now = 1'b0;
    int              cyc;
    logic [7:0]      log_data[$];
    int              log_src[$];
    int              log_cyc[$];

    // reference model
    int         m_owner = -1;
    int         m_cnt = 0;
    int         m_ptr = 0;
    logic [3:0] exp_grant;
    logic [3:0] exp_ack;
    logic       exp_wr;
    logic [7:0] exp_buf_in;

    int n_checks = 0;
    int n_pass = 0;

    function automatic int onehot_idx(input logic [3:0] v);
        int r = -1;
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[IW'(i)]) begin
                r = i;
                n++;
            end
        end
        return (n == 1) ? r : -1;
    endfunction

    task automatic update_inputs();
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (phead[i] < plen[i]) begin
                req[IW'(i)] = req_en[IW'(i)];
                req_data = req_data | (32'(pdata[i][phead[i]]) << (i * DW));
            end else begin
                req[IW'(i)] = 1'b0;
            end
        end
        buf_full = (fq.size() >= 8);
    endtask

    task automatic predict();
        exp_grant  = '0;
        exp_wr     = 1'b0;
        exp_buf_in = '0;
        if (m_owner >= 0) begin
            exp_grant  = 4'(1) << m_owner;
            exp_wr     = req[IW'(m_owner)] && !buf_full;
            exp_buf_in = 8'(req_data >> (m_owner * DW));
        end
        exp_ack = exp_wr ? exp_grant : 4'b0000;
    endtask

    task automatic model_step();
        bit found;
        bit w;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req[IW'((m_ptr + k) % NREQ)]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + k) % NREQ;
                    m_cnt   = 0;
                end
            end
        end else begin
            w = req[IW'(m_owner)] && !buf_full;
            if (w) m_cnt++;
            if (!req[IW'(m_owner)] || (w && m_cnt == BMAX)) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end
    endtask

    task automatic tick();
        logic       d_wr;
        logic [3:0] d_ack;
        logic [7:0] d_data;
        d_wr   = wr_en;
        d_ack  = ack;
        d_data = buf_in;
        @(posedge clock);
        model_step();
        if (pop_now && fq.size() > 0) void'(fq.pop_front());
        if (d_wr) begin
            fq.push_back(d_data);
            log_data.push_back(d_data);
            log_cyc.push_back(cyc);
            log_src.push_back(onehot_idx(d_ack));
        end
        for (int i = 0; i < NREQ; i++) begin
            if (d_ack[IW'(i)]) phead[i]++;
        end
        cyc++;
        @(negedge clock);
        update_inputs();
        predict();
        #1;
    endtask

    task automatic clear_env();
        for (int i = 0; i < NREQ; i++) begin
            phead[i] = 0;
            plen[i]  = 0;
        end
        req_en  = '1;
        pop_now = 1'b0;
        cyc     = 0;
        fq.delete();
        log_data.delete();
        log_src.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        cyc = 0;
        update_inputs();
        predict();
        #1;
    endtask

    task automatic test_reset();
        clear_env();
        reset_n  = 1'b0;
        req      = 4'b1111;
        req_data = 32'hA5A5_A5A5;
        #3;
        n_checks++;
        if ({grant, ack, wr_en, buf_in, grant1, wr_en1} !== '0)
            $display("FAIL reset_hold: grant=%b ack=%b wr_en=%b buf_in=%h grant1=%b, required all zero",
                     grant, ack, wr_en, buf_in, grant1);
        else n_pass++;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({grant, ack, wr_en, buf_in} !== 17'h0)
                $display("FAIL reset_idle c%0d: grant=%b ack=%b wr_en=%b buf_in=%h, required all zero",
                         c, grant, ack, wr_en, buf_in);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_single_stream();
        int exp_c[5] = '{1, 2, 3, 4, 6};
        logic [7:0] gd;
        int gc;
        clear_env();
        for (int k = 0; k < 5; k++) pdata[0][k] = 8'(k + 1);
        plen[0] = 5;
        pop_now = 1'b1;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            n_checks++;
            if ({grant, ack, wr_en, buf_in} !== {exp_grant, exp_ack, exp_wr, exp_buf_in})
                $display("FAIL stream c%0d: grant=%b ack=%b wr_en=%b buf_in=%h, required %b %b %b %h",
                         c, grant, ack, wr_en, buf_in, exp_grant, exp_ack, exp_wr, exp_buf_in);
            else n_pass++;
            if (c == 1) begin
                n_checks++;
                if (grant !== 4'b0001) $display("FAIL stream_first_grant: grant=%b, required 0001", grant);
                else n_pass++;
            end
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            gd = (k < log_data.size()) ? log_data[k] : 8'hFF;
            gc = (k < log_cyc.size()) ? log_cyc[k] : -1;
            n_checks++;
            if (gd !== 8'(k + 1) || gc != exp_c[k])
                $display("FAIL stream_word%0d: data=%0d cycle=%0d, required data=%0d cycle=%0d",
                         k, gd, gc, k + 1, exp_c[k]);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] gd;
        int gs;
        clear_env();
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < 8; k++) pdata[i][k] = 8'(i * 16 + k);
            plen[i] = 8;
        end
        pop_now = 1'b1;
        do_reset();
        for (int c = 0; c < 21; c++) begin
            n_checks++;
            if ({grant, ack, wr_en, buf_in} !== {exp_grant, exp_ack, exp_wr, exp_buf_in})
                $display("FAIL rr c%0d: grant=%b ack=%b wr_en=%b buf_in=%h, required %b %b %b %h",
                         c, grant, ack, wr_en, buf_in, exp_grant, exp_ack, exp_wr, exp_buf_in);
            else n_pass++;
            tick();
        end
        for (int k = 0; k < 16; k++) begin
            gd = (k < log_data.size()) ? log_data[k] : 8'hFF;
            gs = (k < log_src.size()) ? log_src[k] : -1;
            n_checks++;
            if (gs != k / 4 || gd !== 8'((k / 4) * 16 + (k % 4)))
                $display("FAIL rr_order%0d: src=%0d data=%h, required src=%0d data=%h",
                         k, gs, gd, k / 4, 8'((k / 4) * 16 + (k % 4)));
            else n_pass++;
        end
    endtask

    task automatic test_full_stall();
        clear_env();
        for (int k = 0; k < 6; k++) fq.push_back(8'hEE);
        for (int k = 0; k < 8; k++) pdata[2][k] = 8'(8'h20 + k);
        plen[2] = 8;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            n_checks++;
            if ({grant, ack, wr_en, buf_in} !== {exp_grant, exp_ack, exp_wr, exp_buf_in})
                $display("FAIL full c%0d: grant=%b ack=%b wr_en=%b buf_in=%h, required %b %b %b %h",
                         c, grant, ack, wr_en, buf_in, exp_grant, exp_ack, exp_wr, exp_buf_in);
            else n_pass++;
            if ((c >= 3 && c <= 7) || c == 9) begin
                n_checks++;
                if (wr_en !== 1'b0 || ack !== 4'b0000 || grant !== 4'b0100)
                    $display("FAIL full_stall c%0d: wr_en=%b ack=%b grant=%b, required 0 0000 0100",
                             c, wr_en, ack, grant);
                else n_pass++;
            end
            if (c == 8 || c == 10) begin
                n_checks++;
                if (wr_en !== 1'b1 || ack !== 4'b0100)
                    $display("FAIL full_resume c%0d: wr_en=%b ack=%b, required 1 0100", c, wr_en, ack);
                else n_pass++;
            end
            if (c == 11) begin
                n_checks++;
                if (grant !== 4'b0000)
                    $display("FAIL full_burst_end: grant=%b, required 0000", grant);
                else n_pass++;
            end
            pop_now = (c == 7 || c == 9);
            tick();
        end
        pop_now = 1'b0;
    endtask

    task automatic test_drop_req();
        int exp_s[6] = '{1, 1, 3, 3, 3, 3};
        int gs;
        clear_env();
        pdata[1][0] = 8'h11;
        pdata[1][1] = 8'h12;
        plen[1] = 2;
        for (int k = 0; k < 6; k++) pdata[3][k] = 8'(8'h30 + k);
        plen[3] = 6;
        pop_now = 1'b1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if ({grant, ack, wr_en, buf_in} !== {exp_grant, exp_ack, exp_wr, exp_buf_in})
                $display("FAIL drop c%0d: grant=%b ack=%b wr_en=%b buf_in=%h, required %b %b %b %h",
                         c, grant, ack, wr_en, buf_in, exp_grant, exp_ack, exp_wr, exp_buf_in);
            else n_pass++;
            if (c == 5) begin
                n_checks++;
                if (grant !== 4'b1000) $display("FAIL drop_next_grant: grant=%b, required 1000", grant);
                else n_pass++;
            end
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            gs = (k < log_src.size()) ? log_src[k] : -1;
            n_checks++;
            if (gs != exp_s[k]) $display("FAIL drop_src%0d: src=%0d, required %0d", k, gs, exp_s[k]);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        clear_env();
        for (int k = 0; k < 8; k++) pdata[3][k] = 8'(8'h30 + k);
        plen[3] = 8;
        pop_now = 1'b1;
        do_reset();
        for (int c = 0; c < 3; c++) tick();
        n_checks++;
        if (wr_en !== 1'b1 || grant !== 4'b1000)
            $display("FAIL areset_pre: wr_en=%b grant=%b, required 1 1000", wr_en, grant);
        else n_pass++;
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({grant, ack, wr_en, buf_in} !== 17'h0)
            $display("FAIL areset_drop: grant=%b ack=%b wr_en=%b buf_in=%h, required all zero",
                     grant, ack, wr_en, buf_in);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            pdata[1][k] = 8'(8'h10 + k);
            pdata[2][k] = 8'(8'h20 + k);
        end
        plen[1] = 4;
        plen[2] = 4;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            n_checks++;
            if ({grant, ack, wr_en, buf_in} !== {exp_grant, exp_ack, exp_wr, exp_buf_in})
                $display("FAIL areset c%0d: grant=%b ack=%b wr_en=%b buf_in=%h, required %b %b %b %h",
                         c, grant, ack, wr_en, buf_in, exp_grant, exp_ack, exp_wr, exp_buf_in);
            else n_pass++;
            if (c == 1) begin
                n_checks++;
                if (grant !== 4'b0010) $display("FAIL areset_first_grant: grant=%b, required 0010", grant);
                else n_pass++;
            end
            tick();
        end
        n_checks++;
        if (phead[3] != 2) $display("FAIL areset_partial: p3 acked words=%0d, required 2", phead[3]);
        else n_pass++;
    endtask

    task automatic test_burst1();
        logic [7:0] dv;
        logic       a;
        logic [3:0] eg;
        logic       ew;
        clear_env();
        do_reset();
        dv        = 8'h50;
        req1      = 4'b0001;
        req_data1 = {24'h0, dv};
        #1;
        for (int c = 0; c < 10; c++) begin
            ew = (c % 2 == 1);
            eg = ew ? 4'b0001 : 4'b0000;
            n_checks++;
            if ({grant1, ack1, wr_en1, buf_in1} !== {eg, eg, ew, ew ? dv : 8'h00})
                $display("FAIL burst1 c%0d: grant=%b ack=%b wr_en=%b buf_in=%h, required %b %b %b %h",
                         c, grant1, ack1, wr_en1, buf_in1, eg, eg, ew, ew ? dv : 8'h00);
            else n_pass++;
            a = ack1[0];
            @(posedge clock);
            @(negedge clock);
            if (a) dv = dv + 8'h1;
            req_data1 = {24'h0, dv};
            #1;
        end
        req1 = '0;
    endtask

    task automatic test_random();
        int pop_pct;
        int len;
        clear_env();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            n_checks++;
            if ({grant, ack, wr_en, buf_in} !== {exp_grant, exp_ack, exp_wr, exp_buf_in})
                $display("FAIL random c%0d: grant=%b ack=%b wr_en=%b buf_in=%h, required %b %b %b %h",
                         c, grant, ack, wr_en, buf_in, exp_grant, exp_ack, exp_wr, exp_buf_in);
            else n_pass++;
            pop_pct = ((c / 100) % 2 == 0) ? 85 : 30;
            pop_now = ($urandom_range(0, 99) < pop_pct);
            for (int i = 0; i < NREQ; i++) begin
                if (phead[i] >= plen[i] && $urandom_range(0, 3) == 0) begin
                    len = int'($urandom_range(1, 10));
                    for (int k = 0; k < len; k++) pdata[i][k] = 8'($urandom);
                    phead[i] = 0;
                    plen[i]  = len;
                end
                req_en[IW'(i)] = ($urandom_range(0, 9) != 0);
            end
            tick();
        end
        pop_now = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_stream();
        test_round_robin();
        test_full_stall();
        test_drop_req();
        test_async_reset();
        test_burst1();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
